// File: rtl/piso_serializer_if.sv
// Word handshake and serial link bundle between a word source and piso_serializer.
// The slave modport is the serializer's view; the master modport is the source's view.
interface piso_serializer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             ser_o;
    logic             ser_en_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output ser_o,
        output ser_en_o,
        output busy_o,
        output done_o
    );

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  ser_o,
        input  ser_en_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts it out
// MSB first, one strobed bit every BIT_CYCLES clocks, then pulses done for one cycle.
//
// state | meaning
// IDLE  | ready for a word, shreg is zero so the bit line rests low
// SHIFT | word in flight, one strobe every BIT_CYCLES cycles
module piso_serializer #(
    parameter int WIDTH      = 16,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    piso_serializer_if.slave  bus
);
    localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             strobe;

    assign strobe       = (state == SHIFT) && (div == DIV_LAST);
    assign bus.ready_o  = (state == IDLE);
    assign bus.busy_o   = (state == SHIFT);
    assign bus.ser_o    = shreg[WIDTH-1];
    assign bus.ser_en_o = strobe;
    assign bus.done_o   = done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            div   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        shreg <= bus.data_i;
                        div   <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (strobe) begin
                        // zero fill leaves shreg clear by the time we are back in IDLE
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        div   <= '0;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter for 16-bit words. It is the sending end of the serial link whose receiving end is the team's 16-bit serial-in/parallel-out shift register. A word is accepted through a valid/ready handshake and shifted out MSB first, one bit per strobe. The bit line and strobe connect directly to the receiver's data input and enable, so after the last strobe the receiver's parallel output equals the transmitted word.

## Interface
- WIDTH, 16: word width in bits; must match the receiver.
- BIT_CYCLES, 1: clock cycles per bit period; must be ≥ 1.

- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- data_i  input  WIDTH  word to transmit; sampled only on an accepting edge
- valid_i  input  1  data_i holds a word to send
- ready_o  output  1  block can accept a word (state IDLE)
- ser_o  output  1  current serial bit, MSB of the internal shift register
- ser_en_o  output  1  one-cycle strobe; receiver samples ser_o on this edge
- busy_o  output  1  word in flight (state SHIFT)
- done_o  output  1  one-cycle pulse after the last bit of a word

## Operation
- Internal registers:
  - state: IDLE or SHIFT.
  - shreg: WIDTH bits.
  - div: counts 0..BIT_CYCLES-1, width $clog2(BIT_CYCLES) (minimum 1).
  - cnt: bit count 0..WIDTH.
  - done register.
- Reset (edge with reset=1) has priority over everything:
  - state=IDLE, shreg=0, div=0, cnt=0, done_o=0.
  - Resulting outputs: ready_o=1, busy_o=0, ser_o=0, ser_en_o=0.
  - valid_i is ignored on a reset edge.
  - Reset mid-word aborts the word immediately. No further strobes and no done_o.
- Output logic:
  - ready_o = (state==IDLE); busy_o = (state==SHIFT).
  - ser_o = shreg[WIDTH-1].
  - ser_en_o = (state==SHIFT) && (div==BIT_CYCLES-1).
- IDLE:
  - An edge with valid_i && ready_o loads shreg=data_i, sets div=0 and cnt=0, and moves to SHIFT.
  - Otherwise the state holds.
- SHIFT:
  - Each edge with ser_en_o=0: div increments.
  - Each edge with ser_en_o=1:
    - shreg shifts left by one, inserting 0 at bit 0.
    - div resets to 0 and cnt increments.
  - The edge on which the strobe makes cnt reach WIDTH moves the block to IDLE and sets done_o=1 for one cycle.
- valid_i and data_i are ignored while in SHIFT. A held valid_i is accepted on the first IDLE edge.
- shreg is all zeros when it returns to IDLE, so ser_o=0 whenever the block is idle.
- Bit order: data_i[WIDTH-1] is presented with the first strobe and data_i[0] with the last.

## Timing
- Accept edge = edge A, where valid_i && ready_o is sampled.
- Bit k (k=0..WIDTH-1, MSB first):
  - ser_o holds bit k from A+k·BIT_CYCLES through the strobe cycle.
  - ser_en_o is high in the cycle ending at edge A+(k+1)·BIT_CYCLES.
  - Strobes are therefore exactly BIT_CYCLES cycles apart.
- After edge A+WIDTH·BIT_CYCLES:
  - done_o=1 and ready_o=1 in that same cycle.
  - A new word can be accepted at the next edge.
- Throughput: one word per WIDTH·BIT_CYCLES+1 cycles. With defaults, 17 cycles per word and 16 strobes.
- ser_en_o and ready_o are combinational from registers and have no input-to-output path. done_o, ser_o and busy_o come directly from registers.

## Test plan
- Reset:
  - Stimulus: hold reset=1 for 2 edges with valid_i=1 and data_i=16'hFFFF.
  - Required: ready_o=1, busy_o=0, ser_o=0, ser_en_o=0, done_o=0, and no word accepted.
- Loopback, BIT_CYCLES=1:
  - Stimulus: send 16'hA5C3. Connect ser_o/ser_en_o to the 16-bit receiver; its active-low reset is driven from ~reset.
  - Required: exactly 16 consecutive strobes, ser_o sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - Required: done_o one cycle after the last strobe, with receiver output = 16'hA5C3.
- Bit spacing, BIT_CYCLES=3:
  - Stimulus: send 16'h8001.
  - Required: strobes 3 cycles apart, 16 strobes total.
  - Required: done_o at edge A+48+1 cycle, receiver output = 16'h8001.
- Busy ignore:
  - Stimulus: accept 16'h1234, then toggle valid_i and change data_i to 16'hFFFF throughout SHIFT.
  - Required: receiver output = 16'h1234 and exactly one done_o pulse.
- Back-to-back:
  - Stimulus: hold valid_i=1 while sending 16'h0F0F then 16'hF0F0.
  - Required: second accept occurs in the done_o cycle, 17 cycles between accepts.
  - Required: receiver outputs 16'h0F0F, then 16'hF0F0.
- Reset mid-word:
  - Stimulus: assert reset for one edge after the 7th strobe.
  - Required: no further strobes and no done_o, ready_o=1 and ser_o=0 the next cycle.
  - Required: a subsequent 16'h00FF transmits correctly.
